// File: rtl/mem_arbiter.sv
// mem_arbiter: byte-serial RAM/IO port shared by icache line fills and load/store buffer accesses.
// Define ARB_ROUND_ROBIN_EN to alternate grants on contention instead of fixed LS priority.
module mem_arbiter #(
  parameter int LINE_BYTES = 16,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    flush_in,
  input  logic [7:0]              mem_din,
  output logic [7:0]              mem_dout,
  output logic [ADDR_WIDTH-1:0]   mem_a,
  output logic                    mem_wr,
  input  logic                    io_buffer_full,
  input  logic                    ic_req,
  input  logic [ADDR_WIDTH-1:0]   ic_addr,
  output logic                    ic_done,
  output logic [LINE_BYTES*8-1:0] ic_data,
  input  logic                    ls_req,
  input  logic                    ls_we,
  input  logic [1:0]              ls_size,
  input  logic [ADDR_WIDTH-1:0]   ls_addr,
  input  logic [31:0]             ls_wdata,
  output logic                    ls_done,
  output logic [31:0]             ls_rdata
);
  localparam int CW = $clog2(LINE_BYTES);
  localparam int CB = CW + 1;
  localparam logic [1:0] IDLE = 2'd0, IC_RD = 2'd1, LS_RD = 2'd2, LS_WR = 2'd3;
  logic [1:0] state;
  logic [CW:0] cnt, last, ls_last;
  logic [CW-1:0] bi;
  logic [1:0] nb;
  logic [ADDR_WIDTH-1:0] a_nxt;
  logic ls_ok, ic_ok, pick_ls, stall_base, stall_cur, stall_nxt;
  assign bi = cnt[CW-1:0] - 1'b1;
  assign nb = cnt[1:0] + 1'b1;
  assign a_nxt = mem_a + 1'b1;
  assign ls_last = ls_size == 2'd0 ? CB'(0) : ls_size == 2'd1 ? CB'(1) : CB'(3);
  // Writes into the UART window wait while its TX buffer is full
  assign stall_base = ls_addr[17:16] == 2'b11 && io_buffer_full;
  assign stall_cur = mem_a[17:16] == 2'b11 && io_buffer_full;
  assign stall_nxt = a_nxt[17:16] == 2'b11 && io_buffer_full;
  // The done bubble keeps a just-finished request from being granted again
  assign ls_ok = ls_req && (ls_we || !flush_in) && !ic_done && !ls_done;
  assign ic_ok = ic_req && !flush_in && !ic_done && !ls_done;
`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant;
  assign pick_ls = ls_ok && !(ic_ok && last_grant);
`else
  assign pick_ls = ls_ok;
`endif
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
      mem_a <= '0;
      mem_wr <= 1'b0;
      mem_dout <= '0;
      ic_done <= 1'b0;
      ls_done <= 1'b0;
      ic_data <= '0;
      ls_rdata <= '0;
      cnt <= '0;
      last <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant <= 1'b0;
`endif
    end else if (!rdy_in) begin
      mem_wr <= 1'b0;
      ic_done <= 1'b0;
      ls_done <= 1'b0;
    end else begin
      ic_done <= 1'b0;
      ls_done <= 1'b0;
      case (state)
        IDLE:
          if (pick_ls) begin
            state <= ls_we ? LS_WR : LS_RD;
            mem_a <= ls_addr;
            mem_wr <= ls_we && !stall_base;
            mem_dout <= ls_wdata[7:0];
            last <= ls_last;
            cnt <= '0;
            if (!ls_we) ls_rdata <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant <= 1'b1;
`endif
          end else if (ic_ok) begin
            state <= IC_RD;
            mem_a <= ic_addr;
            mem_wr <= 1'b0;
            last <= CB'(LINE_BYTES - 1);
            cnt <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant <= 1'b0;
`endif
          end
        IC_RD, LS_RD:
          if (flush_in) begin
            state <= IDLE;
            mem_wr <= 1'b0;
          end else begin
            // RAM data trails the address by one cycle, so capture lags cnt by one
            if (cnt != '0) begin
              if (state == IC_RD) ic_data[{bi, 3'b000} +: 8] <= mem_din;
              else ls_rdata[{bi[1:0], 3'b000} +: 8] <= mem_din;
            end
            if (cnt == last + 1'b1) begin
              state <= IDLE;
              ic_done <= state == IC_RD;
              ls_done <= state == LS_RD;
            end else begin
              cnt <= cnt + 1'b1;
              if (cnt != last) mem_a <= a_nxt;
            end
          end
        default:
          if (!mem_wr) mem_wr <= !stall_cur;
          else if (cnt == last) begin
            state <= IDLE;
            mem_wr <= 1'b0;
            ls_done <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
            mem_a <= a_nxt;
            mem_dout <= ls_wdata[{nb, 3'b000} +: 8];
            mem_wr <= !stall_nxt;
          end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven checks of mem_arbiter against a byte RAM model, plus multi-cycle corner sequences.
module tb_mem_arbiter;
  logic clk_in = 1'b0, rst_in = 1'b1, rdy_in = 1'b1, flush_in = 1'b0;
  logic [7:0] mem_din = 8'h00, mem_dout;
  logic [31:0] mem_a;
  logic mem_wr, io_buffer_full = 1'b0;
  logic ic_req = 1'b0, ic_done;
  logic [31:0] ic_addr = '0;
  logic [127:0] ic_data;
  logic ls_req = 1'b0, ls_we = 1'b0, ls_done;
  logic [1:0] ls_size = 2'd0;
  logic [31:0] ls_addr = '0, ls_wdata = '0, ls_rdata;
  logic [7:0] ram [0:1023];
  int n_chk = 0, n_err = 0;
  typedef struct {
    logic ic;
    logic we;
    logic [1:0] size;
    logic [31:0] addr;
    logic [31:0] wdata;
    int n;
    int lat;
    logic [127:0] exp;
  } vec_t;
  vec_t vecs [14];
  vec_t v;
  int who [3];
  int at [3];
  int k, cyc, cnt_x;
  mem_arbiter dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(ic_done), .ic_data(ic_data),
    .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata)
  );
  always #5 clk_in = ~clk_in;
  // The RAM read port is paused together with the CPU while rdy_in is low
  always @(posedge clk_in) if (rdy_in) begin
    mem_din <= ram[mem_a[9:0]];
    if (mem_wr && mem_a[17:16] != 2'b11) ram[mem_a[9:0]] <= mem_dout;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic reset_dut;
    @(negedge clk_in);
    rst_in = 1'b1;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
  endtask
  task automatic run(input vec_t t, input string nm);
    int c;
    bit done_seen, wr_seen;
    logic [31:0] la;
    la = t.addr + 32'(t.n - 1);
    @(negedge clk_in);
    ic_req = t.ic;
    ls_req = !t.ic;
    ls_we = t.we;
    ls_size = t.size;
    ls_addr = t.addr;
    ic_addr = t.addr;
    ls_wdata = t.wdata;
    c = 0;
    done_seen = 0;
    wr_seen = 0;
    while (!done_seen && c < 40) begin
      @(negedge clk_in);
      c++;
      if (c == 1) chk({nm, " first addr"}, mem_a, t.addr);
      if (c == t.n) chk({nm, " last addr"}, mem_a, la);
      if (mem_wr) wr_seen = 1;
      done_seen = t.ic ? ic_done : ls_done;
    end
    ic_req = 0;
    ls_req = 0;
    chk({nm, " latency"}, c, t.lat);
    chk({nm, " wrote"}, wr_seen, t.we);
    if (!t.we) chk({nm, " data"}, t.ic ? ic_data : {96'b0, ls_rdata}, t.exp);
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 8'(i);
    ram[256] = 8'h11; ram[257] = 8'h22; ram[258] = 8'h33; ram[259] = 8'h44;
    vecs[0]  = '{1'b0, 1'b0, 2'd2, 32'h100, 32'h0, 4, 6, 128'h44332211};
    vecs[1]  = '{1'b0, 1'b0, 2'd1, 32'h102, 32'h0, 2, 4, 128'h4433};
    vecs[2]  = '{1'b0, 1'b0, 2'd0, 32'h103, 32'h0, 1, 3, 128'h44};
    vecs[3]  = '{1'b0, 1'b0, 2'd3, 32'h100, 32'h0, 4, 6, 128'h44332211};
    vecs[4]  = '{1'b1, 1'b0, 2'd0, 32'h000, 32'h0, 16, 18, 128'h0F0E0D0C0B0A09080706050403020100};
    vecs[5]  = '{1'b1, 1'b0, 2'd0, 32'h040, 32'h0, 16, 18, 128'h4F4E4D4C4B4A49484746454443424140};
    vecs[6]  = '{1'b0, 1'b1, 2'd2, 32'h200, 32'hDEADBEEF, 4, 5, 128'h0};
    vecs[7]  = '{1'b0, 1'b0, 2'd2, 32'h200, 32'h0, 4, 6, 128'hDEADBEEF};
    vecs[8]  = '{1'b0, 1'b1, 2'd1, 32'h210, 32'h1234ABCD, 2, 3, 128'h0};
    vecs[9]  = '{1'b0, 1'b0, 2'd2, 32'h210, 32'h0, 4, 6, 128'h1312ABCD};
    vecs[10] = '{1'b0, 1'b1, 2'd0, 32'h2F0, 32'h000000A5, 1, 2, 128'h0};
    vecs[11] = '{1'b0, 1'b0, 2'd0, 32'h2F0, 32'h0, 1, 3, 128'hA5};
    vecs[12] = '{1'b0, 1'b0, 2'd2, 32'hFFFFFFFE, 32'h0, 4, 6, 128'h0100FFFE};
    vecs[13] = '{1'b0, 1'b0, 2'd1, 32'h2F0, 32'h0, 2, 4, 128'hF1A5};
    reset_dut();
    @(negedge clk_in);
    chk("reset mem_a", mem_a, 0);
    chk("reset mem_wr", mem_wr, 0);
    chk("reset mem_dout", mem_dout, 0);
    chk("reset dones", {ic_done, ls_done}, 0);
    chk("reset ic_data", ic_data, 0);
    chk("reset ls_rdata", ls_rdata, 0);
    for (int i = 0; i < 14; i++) run(vecs[i], $sformatf("v%0d", i));
    // Simultaneous requests held high across several grants
    reset_dut();
    @(negedge clk_in);
    ic_addr = 32'h0; ls_addr = 32'h100; ls_we = 0; ls_size = 2'd2;
    ic_req = 1; ls_req = 1;
    k = 0;
    cyc = 0;
    while (k < 3 && cyc < 200) begin
      @(negedge clk_in);
      cyc++;
      if (ls_done || ic_done) begin
        who[k] = ls_done ? 1 : 0;
        at[k] = cyc;
        k++;
      end
    end
    ic_req = 0;
    ls_req = 0;
    chk("contention grants", k, 3);
`ifdef ARB_ROUND_ROBIN_EN
    chk("rr order", {who[0][0], who[1][0], who[2][0]}, 3'b101);
    chk("rr timing", {at[0][7:0], at[1][7:0], at[2][7:0]}, {8'd6, 8'd25, 8'd32});
`else
    chk("prio order", {who[0][0], who[1][0], who[2][0]}, 3'b111);
    chk("prio timing", {at[0][7:0], at[1][7:0], at[2][7:0]}, {8'd6, 8'd13, 8'd20});
`endif
    repeat (25) @(negedge clk_in);
    // Byte store into the IO window while the TX buffer is full
    ls_req = 1; ls_we = 1; ls_size = 2'd0; ls_addr = 32'h30000; ls_wdata = 32'h41;
    io_buffer_full = 1;
    cnt_x = 0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk_in);
      if (!mem_wr) cnt_x++;
      if (i == 5) io_buffer_full = 0;
    end
    chk("io stall low cycles", cnt_x, 5);
    @(negedge clk_in);
    chk("io issue wr", mem_wr, 1);
    chk("io issue dout", mem_dout, 8'h41);
    chk("io issue addr", mem_a, 32'h30000);
    chk("io early done", ls_done, 0);
    @(negedge clk_in);
    chk("io done", ls_done, 1);
    chk("io wr after", mem_wr, 0);
    ls_req = 0;
    // Flush at icache byte 7 aborts the fill
    @(negedge clk_in);
    ic_req = 1; ic_addr = 32'h80;
    repeat (8) @(negedge clk_in);
    chk("flush ic byte7 addr", mem_a, 32'h87);
    flush_in = 1; ic_req = 0;
    @(negedge clk_in);
    flush_in = 0;
    cnt_x = ic_done;
    @(negedge clk_in);
    chk("flush ic addr frozen", mem_a, 32'h87);
    repeat (25) begin
      if (ic_done) cnt_x++;
      @(negedge clk_in);
    end
    chk("flush ic no done", cnt_x, 0);
    // Flush coinciding with the final byte capture of a load
    ls_req = 1; ls_we = 0; ls_size = 2'd2; ls_addr = 32'h100;
    repeat (5) @(negedge clk_in);
    flush_in = 1; ls_req = 0;
    @(negedge clk_in);
    flush_in = 0;
    cnt_x = 0;
    repeat (15) begin
      if (ls_done) cnt_x++;
      @(negedge clk_in);
    end
    chk("flush final no done", cnt_x, 0);
    // Half store is committed even with flush raised
    ls_req = 1; ls_we = 1; ls_size = 2'd1; ls_addr = 32'h220; ls_wdata = 32'h5555BEEF;
    flush_in = 1;
    cyc = 0;
    do begin
      @(negedge clk_in);
      cyc++;
      if (cyc == 2) flush_in = 0;
    end while (!ls_done && cyc < 20);
    ls_req = 0;
    flush_in = 0;
    chk("flush store latency", cyc, 3);
    v = '{1'b0, 1'b0, 2'd2, 32'h220, 32'h0, 4, 6, 128'h2322BEEF};
    run(v, "flush store readback");
    // Three paused cycles in the middle of a word load
    @(negedge clk_in);
    ls_req = 1; ls_we = 0; ls_size = 2'd2; ls_addr = 32'h100;
    cyc = 0;
    cnt_x = 0;
    do begin
      @(negedge clk_in);
      cyc++;
      if (cyc >= 3 && cyc <= 5 && mem_wr) cnt_x++;
      if (cyc == 5) chk("pause addr frozen", mem_a, 32'h101);
      if (cyc == 2) rdy_in = 0;
      if (cyc == 5) rdy_in = 1;
    end while (!ls_done && cyc < 40);
    ls_req = 0;
    rdy_in = 1;
    chk("pause mem_wr", cnt_x, 0);
    chk("pause latency", cyc, 9);
    chk("pause data", ls_rdata, 32'h44332211);
    // Reset in the middle of a line fill
    @(negedge clk_in);
    ic_req = 1; ic_addr = 32'h0;
    repeat (5) @(negedge clk_in);
    rst_in = 1; ic_req = 0;
    @(negedge clk_in);
    rst_in = 0;
    chk("mid reset addr", mem_a, 0);
    cnt_x = 0;
    repeat (25) begin
      @(negedge clk_in);
      if (ic_done) cnt_x++;
    end
    chk("mid reset no done", cnt_x, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
